// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the rx frame router.
// State encoding, error codes and default framing bytes.
package rx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TYPE    = 3'd1,
        LEN_HI  = 3'd2,
        LEN_LO  = 3'd3,
        PAYLOAD = 3'd4,
        CSUM    = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_TYPE = 3'd1;
    localparam logic [2:0] ERR_ZERO_LEN = 3'd2;
    localparam logic [2:0] ERR_CSUM     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_OVF      = 3'd5;

    localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] DEF_TYPE_WEIGHT = 8'h01;
    localparam logic [7:0] DEF_TYPE_DATA   = 8'h02;

endpackage

// File: rtl/rx_idle_timer.sv
// Inter-byte idle counter for the frame router.
// Counts enabled clocks since the last clear; flags expiry at TIMEOUT_CYC-1.
module rx_idle_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] count;

    assign expired = enable && (count == W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/rx_frame_router.sv
// Parses SYNC|TYPE|LEN_HI|LEN_LO|payload|CSUM frames from the UART byte
// stream and forwards payload bytes to the weight or data FIFO.
module rx_frame_router
    import rx_frame_pkg::*;
#(
    parameter int              W_DATA      = 8,
    parameter int              W_LEN       = 16,
    parameter logic [W_DATA-1:0] SYNC_BYTE   = DEF_SYNC_BYTE,
    parameter logic [W_DATA-1:0] TYPE_WEIGHT = DEF_TYPE_WEIGHT,
    parameter logic [W_DATA-1:0] TYPE_DATA   = DEF_TYPE_DATA,
    parameter int              TIMEOUT_CYC = 100000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_dv,
    input  logic [W_DATA-1:0] i_rx_byte,
    input  logic              i_full_1,
    input  logic              i_full_2,
    output logic              o_rx_dv,
    output logic [W_DATA-1:0] o_data,
    output logic              o_fifo_sel_1,
    output logic              o_fifo_sel_2,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic [2:0]        o_err_code
);

    state_t            state_q, state_d;
    logic              route_q, route_d;
    logic [W_DATA-1:0] len_hi_q, len_hi_d;
    logic [W_LEN-1:0]  rem_q, rem_d;
    logic [W_DATA-1:0] csum_q, csum_d;
    logic              ovf_q, ovf_d;

    logic              dv_d;
    logic [W_DATA-1:0] data_d;
    logic              sel1_d, sel2_d;
    logic              busy_d;
    logic              done_d, err_d;
    logic [2:0]        code_d;

    logic [W_LEN-1:0]  len_w;
    logic              tgt_full;
    logic              expired;
    logic              in_frame;

    assign in_frame = (state_q != IDLE);

    rx_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (i_clk),
        .rst    (i_rst),
        .clear  (i_rx_dv || !in_frame || expired),
        .enable (in_frame),
        .expired(expired)
    );

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        len_hi_d = len_hi_q;
        rem_d    = rem_q;
        csum_d   = csum_q;
        ovf_d    = ovf_q;
        code_d   = o_err_code;
        dv_d     = 1'b0;
        data_d   = o_data;
        sel1_d   = 1'b0;
        sel2_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        len_w    = W_LEN'({len_hi_q, i_rx_byte});
        tgt_full = route_q ? i_full_2 : i_full_1;

        // Expiry wins over a byte arriving in the same cycle.
        if (expired) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
        end else if (i_rx_dv) begin
            unique case (state_q)
                IDLE: begin
                    if (i_rx_byte == SYNC_BYTE) state_d = TYPE;
                end
                TYPE: begin
                    if (i_rx_byte == TYPE_WEIGHT) begin
                        route_d = 1'b0;
                        state_d = LEN_HI;
                    end else if (i_rx_byte == TYPE_DATA) begin
                        route_d = 1'b1;
                        state_d = LEN_HI;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_BAD_TYPE;
                        state_d = IDLE;
                    end
                end
                LEN_HI: begin
                    len_hi_d = i_rx_byte;
                    state_d  = LEN_LO;
                end
                LEN_LO: begin
                    if (len_w == '0) begin
                        err_d   = 1'b1;
                        code_d  = ERR_ZERO_LEN;
                        state_d = IDLE;
                    end else begin
                        rem_d   = len_w;
                        csum_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    csum_d = csum_q + i_rx_byte;
                    rem_d  = rem_q - W_LEN'(1);
                    // A full target drops the byte but the frame runs on.
                    if (tgt_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        dv_d   = 1'b1;
                        data_d = i_rx_byte;
                        sel1_d = !route_q;
                        sel2_d = route_q;
                    end
                    if (rem_q == W_LEN'(1)) state_d = CSUM;
                end
                CSUM: begin
                    if (ovf_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_OVF;
                    end else if (i_rx_byte != csum_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end else begin
                        done_d = 1'b1;
                        code_d = ERR_NONE;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            route_q  <= 1'b0;
            len_hi_q <= '0;
            rem_q    <= '0;
            csum_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            len_hi_q <= len_hi_d;
            rem_q    <= rem_d;
            csum_q   <= csum_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rx_dv      <= 1'b0;
            o_data       <= '0;
            o_fifo_sel_1 <= 1'b0;
            o_fifo_sel_2 <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            o_err_code   <= ERR_NONE;
        end else begin
            o_rx_dv      <= dv_d;
            o_data       <= data_d;
            o_fifo_sel_1 <= sel1_d;
            o_fifo_sel_2 <= sel2_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_frame_err  <= err_d;
            o_err_code   <= code_d;
        end
    end

endmodule
